// File: rtl/bus_rr_arbiter_if.sv
// Host/device bus bundle for the round-robin arbiter.
// Member names carry the arbiter's point of view (_i into the arbiter, _o out of it).
// The slave modport is the arbiter itself; the master modport is everything around
// it (the requesting hosts, the devices and the window configuration).
interface bus_rr_arbiter_if #(
   parameter int unsigned NrHosts      = 2,
   parameter int unsigned NrDevices    = 1,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned AddressWidth = 32
);

   // Host side
   logic [NrHosts-1:0]                   host_req_i;
   logic [NrHosts-1:0]                   host_gnt_o;
   logic [NrHosts-1:0][AddressWidth-1:0] host_addr_i;
   logic [NrHosts-1:0]                   host_we_i;
   logic [NrHosts-1:0][DataWidth-1:0]    host_wdata_i;
   logic [NrHosts-1:0]                   host_rvalid_o;
   logic [NrHosts-1:0]                   host_err_o;
   logic [NrHosts-1:0][DataWidth-1:0]    host_rdata_o;

   // Device side
   logic [NrDevices-1:0]                   device_req_o;
   logic [NrDevices-1:0][AddressWidth-1:0] device_addr_o;
   logic [NrDevices-1:0]                   device_we_o;
   logic [NrDevices-1:0][DataWidth-1:0]    device_wdata_o;
   logic [NrDevices-1:0][DataWidth-1:0]    device_rdata_i;

   // Address window configuration
   logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_base;
   logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_mask;

   modport slave (
      input  host_req_i, host_addr_i, host_we_i, host_wdata_i,
      output host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
      output device_req_o, device_addr_o, device_we_o, device_wdata_o,
      input  device_rdata_i,
      input  cfg_device_addr_base, cfg_device_addr_mask
   );

   modport master (
      output host_req_i, host_addr_i, host_we_i, host_wdata_i,
      input  host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
      input  device_req_o, device_addr_o, device_we_o, device_wdata_o,
      output device_rdata_i,
      output cfg_device_addr_base, cfg_device_addr_mask
   );

endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter: shares the device ports among NrHosts requesters,
// decodes the winner's address against base/mask windows and routes the
// one-cycle-latency device response back to the host that was granted.
module bus_rr_arbiter #(
   parameter int unsigned NrHosts      = 2,
   parameter int unsigned NrDevices    = 1,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned AddressWidth = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   bus_rr_arbiter_if.slave bus
);

   localparam int unsigned HostIdxW = (NrHosts > 1)   ? $clog2(NrHosts)   : 1;
   localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

   // Arbitration pointer and the captured response context
   logic [HostIdxW-1:0] prio_q, prio_d;
   logic [HostIdxW-1:0] host_q, host_d;
   logic [DevIdxW-1:0]  dev_q, dev_d;
   logic                miss_q, miss_d;
   logic                rvalid_q, rvalid_d;

   // Combinational grant and decode results for the current cycle
   logic                    gntValid;
   logic [HostIdxW-1:0]     gntIdx;
   logic [AddressWidth-1:0] winAddr;
   logic                    winWe;
   logic [DataWidth-1:0]    winWdata;
   logic                    hitAny;
   logic [DevIdxW-1:0]      hitIdx;

   // Round-robin pick: first requester at or above prio_q, otherwise wrap to the
   // lowest requester below it. Two passes avoid a modulo on the index.
   always_comb begin
      gntValid = 1'b0;
      gntIdx   = '0;
      for (int h = 0; h < int'(NrHosts); h++) begin
         if (!gntValid && bus.host_req_i[h] && (h >= int'(prio_q))) begin
            gntValid = 1'b1;
            gntIdx   = HostIdxW'(h);
         end
      end
      for (int h = 0; h < int'(NrHosts); h++) begin
         if (!gntValid && bus.host_req_i[h]) begin
            gntValid = 1'b1;
            gntIdx   = HostIdxW'(h);
         end
      end
   end

   // One-hot grant back to the hosts
   always_comb begin
      bus.host_gnt_o = '0;
      if (gntValid) begin
         bus.host_gnt_o[gntIdx] = 1'b1;
      end
   end

   // Winner's request fields; forced to zero when nobody is granted
   always_comb begin
      winAddr  = '0;
      winWe    = 1'b0;
      winWdata = '0;
      if (gntValid) begin
         winAddr  = bus.host_addr_i[gntIdx];
         winWe    = bus.host_we_i[gntIdx];
         winWdata = bus.host_wdata_i[gntIdx];
      end
   end

   // Address decode: lowest-indexed window that matches wins on overlap
   always_comb begin
      hitAny = 1'b0;
      hitIdx = '0;
      for (int d = 0; d < int'(NrDevices); d++) begin
         if (!hitAny &&
             ((winAddr & bus.cfg_device_addr_mask[d]) == bus.cfg_device_addr_base[d])) begin
            hitAny = 1'b1;
            hitIdx = DevIdxW'(d);
         end
      end
   end

   // Device strobes: address/data broadcast, req and we only to the decoded device
   always_comb begin
      bus.device_req_o = '0;
      bus.device_we_o  = '0;
      for (int d = 0; d < int'(NrDevices); d++) begin
         bus.device_addr_o[d]  = winAddr;
         bus.device_wdata_o[d] = winWdata;
      end
      if (gntValid && hitAny) begin
         bus.device_req_o[hitIdx] = 1'b1;
         bus.device_we_o[hitIdx]  = winWe;
      end
   end

   // Next state: advance the pointer past the winner and remember who to answer
   always_comb begin
      prio_d   = prio_q;
      host_d   = host_q;
      dev_d    = dev_q;
      miss_d   = miss_q;
      rvalid_d = gntValid;
      if (gntValid) begin
         prio_d = (gntIdx == HostIdxW'(NrHosts - 1)) ? '0 : gntIdx + 1'b1;
         host_d = gntIdx;
         dev_d  = hitIdx;
         miss_d = !hitAny;
      end
   end

   // State registers; reset drops any in-flight response immediately
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prio_q   <= '0;
         host_q   <= '0;
         dev_q    <= '0;
         miss_q   <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         prio_q   <= prio_d;
         host_q   <= host_d;
         dev_q    <= dev_d;
         miss_q   <= miss_d;
         rvalid_q <= rvalid_d;
      end
   end

   // Response routing: only the host granted last cycle sees rvalid/err/rdata
   always_comb begin
      bus.host_rvalid_o = '0;
      bus.host_err_o    = '0;
      bus.host_rdata_o  = '0;
      if (rvalid_q) begin
         bus.host_rvalid_o[host_q] = 1'b1;
         bus.host_err_o[host_q]    = miss_q;
         if (!miss_q) begin
            bus.host_rdata_o[host_q] = bus.device_rdata_i[dev_q];
         end
      end
   end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter with two hosts and two device windows.
// A reference arbiter/decoder predicts grants and device strobes each cycle and
// queues the expected response, which is popped after the following clock edge.
module tb_bus_rr_arbiter;

   localparam int NrHosts      = 2;
   localparam int NrDevices    = 2;
   localparam int DataWidth    = 32;
   localparam int AddressWidth = 32;

   typedef struct {
      int          host;
      logic        err;
      logic [31:0] rdata;
   } resp_t;

   logic clk = 1'b0;
   logic rstN;

   int checkCount = 0;
   int errorCount = 0;

   // Bench-side copy of the stimulus and configuration
   logic        reqV   [NrHosts];
   logic [31:0] addrV  [NrHosts];
   logic        weV    [NrHosts];
   logic [31:0] wdataV [NrHosts];
   logic [31:0] cfgBase [NrDevices];
   logic [31:0] cfgMask [NrDevices];

   // Reference model state
   int          modelPrio;
   logic [31:0] refMem [256];
   resp_t       respQ [$];

   bus_rr_arbiter_if #(
      .NrHosts(NrHosts), .NrDevices(NrDevices),
      .DataWidth(DataWidth), .AddressWidth(AddressWidth)
   ) bus ();

   bus_rr_arbiter #(
      .NrHosts(NrHosts), .NrDevices(NrDevices),
      .DataWidth(DataWidth), .AddressWidth(AddressWidth)
   ) dut (
      .clk_i (clk),
      .rst_ni(rstN),
      .bus   (bus)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   function automatic logic [31:0] initWord(input int i);
      return (i == 64) ? 32'h1234_5678 : (32'hA500_0000 | 32'(i));
   endfunction

   // Device models: dev0 is a 256-word RAM returning pre-write data,
   // dev1 is a read-only pattern source. Both answer one cycle after req.
   logic        memLoaded = 1'b0;
   logic [31:0] devMem [256];
   logic [31:0] dev0Rdata = '0;
   logic [31:0] dev1Rdata = '0;

   always @(posedge clk) begin
      if (!memLoaded) begin
         for (int i = 0; i < 256; i++) devMem[i] <= initWord(i);
         memLoaded <= 1'b1;
      end else if (bus.device_req_o[0]) begin
         dev0Rdata <= devMem[bus.device_addr_o[0][9:2]];
         if (bus.device_we_o[0]) devMem[bus.device_addr_o[0][9:2]] <= bus.device_wdata_o[0];
      end
      if (bus.device_req_o[1]) dev1Rdata <= 32'hB000_0000 ^ bus.device_addr_o[1];
   end

   assign bus.device_rdata_i = {dev1Rdata, dev0Rdata};

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input int h, input logic req, input logic [31:0] addr,
                                input logic we, input logic [31:0] wdata);
      reqV[h]   = req;
      addrV[h]  = addr;
      weV[h]    = we;
      wdataV[h] = wdata;
      bus.host_req_i[h]   = req;
      bus.host_addr_i[h]  = addr;
      bus.host_we_i[h]    = we;
      bus.host_wdata_i[h] = wdata;
   endtask

   task automatic clearStimulus();
      for (int h = 0; h < NrHosts; h++) applyStimulus(h, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic setWindow(input int d, input logic [31:0] base, input logic [31:0] mask);
      cfgBase[d] = base;
      cfgMask[d] = mask;
      bus.cfg_device_addr_base[d] = base;
      bus.cfg_device_addr_mask[d] = mask;
   endtask

   function automatic int decodeRef(input logic [31:0] addr);
      for (int d = 0; d < NrDevices; d++) begin
         if ((addr & cfgMask[d]) == cfgBase[d]) return d;
      end
      return -1;
   endfunction

   // One clock cycle starting at a falling edge: check grant/strobes mid-low-phase,
   // queue the expected response, then check the response just after the rising edge.
   task automatic runCycle(output int win);
      logic [NrHosts-1:0]           expGnt;
      logic [NrDevices-1:0]         expDevReq;
      logic [NrDevices-1:0]         expDevWe;
      logic [31:0]                  expAddr;
      logic [31:0]                  expWdata;
      logic [NrHosts-1:0]           expValid;
      logic [NrHosts-1:0]           expErr;
      logic [NrHosts*DataWidth-1:0] expRdata;
      int    dev;
      resp_t r;

      #1;
      win = -1;
      for (int k = 0; k < NrHosts; k++) begin
         int h;
         h = (modelPrio + k) % NrHosts;
         if (win < 0 && reqV[h]) win = h;
      end

      expGnt    = '0;
      expDevReq = '0;
      expDevWe  = '0;
      expAddr   = '0;
      expWdata  = '0;
      dev       = -1;
      if (win >= 0) begin
         expGnt[win] = 1'b1;
         expAddr     = addrV[win];
         expWdata    = wdataV[win];
         dev         = decodeRef(addrV[win]);
         if (dev >= 0) begin
            expDevReq[dev] = 1'b1;
            if (weV[win]) expDevWe[dev] = 1'b1;
         end
      end

      checkOutput("gnt",       bus.host_gnt_o,      expGnt);
      checkOutput("devReq",    bus.device_req_o,    expDevReq);
      checkOutput("devWe",     bus.device_we_o,     expDevWe);
      checkOutput("devAddr0",  bus.device_addr_o[0], expAddr);
      checkOutput("devWdata1", bus.device_wdata_o[1], expWdata);

      if (win >= 0) begin
         r.host  = win;
         r.err   = (dev < 0);
         r.rdata = 32'h0;
         if (dev == 0) begin
            r.rdata = refMem[addrV[win][9:2]];
            if (weV[win]) refMem[addrV[win][9:2]] = wdataV[win];
         end else if (dev == 1) begin
            r.rdata = 32'hB000_0000 ^ addrV[win];
         end
         respQ.push_back(r);
         modelPrio = (win + 1) % NrHosts;
      end

      @(posedge clk);
      #1;
      expValid = '0;
      expErr   = '0;
      expRdata = '0;
      if (respQ.size() > 0) begin
         r = respQ.pop_front();
         expValid[r.host] = 1'b1;
         expErr[r.host]   = r.err;
         expRdata[r.host*DataWidth +: DataWidth] = r.rdata;
      end
      checkOutput("rvalid", bus.host_rvalid_o, expValid);
      checkOutput("err",    bus.host_err_o,    expErr);
      checkOutput("rdata",  bus.host_rdata_o,  expRdata);
      @(negedge clk);
   endtask

   // Main sequence
   initial begin
      int win;
      logic granted [NrHosts];

      rstN      = 1'b0;
      modelPrio = 0;
      for (int i = 0; i < 256; i++) refMem[i] = initWord(i);
      clearStimulus();
      setWindow(0, 32'h0000_0000, 32'hFFF0_0000);
      setWindow(1, 32'h0010_0000, 32'hFFF0_0000);

      // Reset state
      #1;
      checkOutput("rstRvalid", bus.host_rvalid_o, '0);
      checkOutput("rstErr",    bus.host_err_o,    '0);
      checkOutput("rstRdata",  bus.host_rdata_o,  '0);
      checkOutput("rstDevReq", bus.device_req_o,  '0);
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      $display("[TB] reset released");

      // Host0 read hitting dev0
      applyStimulus(0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
      runCycle(win);

      // Host1 read missing every window
      clearStimulus();
      applyStimulus(1, 1'b1, 32'h0020_0000, 1'b0, 32'h0);
      runCycle(win);

      // Host0 write then read-back
      clearStimulus();
      applyStimulus(0, 1'b1, 32'h0000_0040, 1'b1, 32'hDEAD_BEEF);
      runCycle(win);
      applyStimulus(0, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
      runCycle(win);

      // Overlapping windows: lowest index wins
      setWindow(1, 32'h0000_0000, 32'hFFF0_0000);
      applyStimulus(0, 1'b1, 32'h0000_0000, 1'b0, 32'h0);
      runCycle(win);
      setWindow(1, 32'h0010_0000, 32'hFFF0_0000);

      // Host1 read from dev1, then an idle cycle
      clearStimulus();
      applyStimulus(1, 1'b1, 32'h0010_0010, 1'b0, 32'h0);
      runCycle(win);
      clearStimulus();
      runCycle(win);

      // Async reset in the cycle after a grant drops the response without a clock edge
      applyStimulus(0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
      runCycle(win);
      clearStimulus();
      #1;
      checkOutput("preRstRvalid", bus.host_rvalid_o, 2'b01);
      rstN = 1'b0;
      #1;
      checkOutput("midRstRvalid", bus.host_rvalid_o, '0);
      checkOutput("midRstRdata",  bus.host_rdata_o,  '0);
      respQ.delete();
      modelPrio = 0;
      @(negedge clk);
      rstN = 1'b1;

      // Both hosts requesting continuously from reset: alternate 0,1,0,1,...
      applyStimulus(0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
      applyStimulus(1, 1'b1, 32'h0010_0004, 1'b0, 32'h0);
      for (int c = 0; c < 6; c++) begin
         runCycle(win);
         checkOutput("rrOrder", 32'(win), 32'(c % 2));
      end

      // Random traffic; a host keeps its request stable until it is granted
      for (int h = 0; h < NrHosts; h++) granted[h] = 1'b1;
      for (int c = 0; c < 40; c++) begin
         for (int h = 0; h < NrHosts; h++) begin
            if (!reqV[h] || granted[h]) begin
               logic [31:0] a;
               case ($urandom_range(0, 2))
                  0:       a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                  1:       a = 32'h0010_0000 | {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                  default: a = 32'h0020_0000 | {22'h0, 8'($urandom_range(0, 255)), 2'b00};
               endcase
               applyStimulus(h, ($urandom_range(0, 3) != 0), a,
                             1'($urandom_range(0, 1)), $urandom);
            end
         end
         runCycle(win);
         for (int h = 0; h < NrHosts; h++) granted[h] = (win == h);
      end

      clearStimulus();
      runCycle(win);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
